// File: rtl/bus_arbiter_if.sv
// Bundle of the two requester ports, the registered output port and the
// bus-mux status lines; slave = arbiter side, master = environment side.
interface bus_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    logic             sel;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_last,
        output sel, busy
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_last,
        input  sel, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester burst arbiter with a registered valid/ready output beat.
// Ports: clk, reset_n (async, active-low), bus (bus_arbiter_if.slave).
// Option: BUS_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module bus_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic             rdy0, rdy1;
    logic             xfer;
    logic             win;
    logic [WIDTH-1:0] src_data;
    logic             src_last;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        xfer        = 1'b0;
        win         = 1'b0;
        src_data    = bus.req0_data;
        src_last    = bus.req0_last;

        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
                    win = 1'b0;
`else
                    // The requester that did not own the bus last wins.
                    win = ~sel_q;
`endif
                    state_d = win ? OWN1 : OWN0;
                    sel_d   = win;
                end else if (bus.req0_valid) begin
                    state_d = OWN0;
                    sel_d   = 1'b0;
                end else if (bus.req1_valid) begin
                    state_d = OWN1;
                    sel_d   = 1'b1;
                end
            end
            OWN0: begin
                rdy0 = ~out_valid_q | bus.out_ready;
                xfer = bus.req0_valid & rdy0;
            end
            OWN1: begin
                rdy1     = ~out_valid_q | bus.out_ready;
                xfer     = bus.req1_valid & rdy1;
                src_data = bus.req1_data;
                src_last = bus.req1_last;
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            // Load wins over drain so the output can stream every cycle.
            out_valid_d = 1'b1;
            out_data_d  = src_data;
            out_last_d  = src_last;
            if (src_last || (cnt_q + 8'd1) == MAX_B) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b1;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter that shares the 4-bit select-multiplexed bus between two producers. It grants the bus in whole bursts and drives the select line of the downstream 2:1 bus mux. It registers the winning beat onto a single valid/ready output port. Round-robin fairness and a maximum burst length bound how long either requester can be starved.

## Interface
- WIDTH, 4, data width of each requester and the output bus
- MAX_BURST, 8, beats per grant before forced release; legal range 1..255
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a beat
- req0_data  input  WIDTH  requester 0 beat data
- req0_last  input  1  final beat of requester 0 burst
- req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid
- req1_valid, req1_data, req1_last, req1_ready: same as requester 0, for requester 1
- out_valid  output  1  output beat valid
- out_data  output  WIDTH  output beat data
- out_last  output  1  copy of the accepted beat's last flag
- out_ready  input  1  downstream accepts the output beat
- sel  output  1  bus mux select: 0 = requester 0, 1 = requester 1
- busy  output  1  high while in OWN0 or OWN1

## Operation
- The FSM has three states: IDLE, OWN0 and OWN1. A registered last-grant bit drives `sel`.
- **IDLE**
  - No valids: stay in IDLE.
  - One valid: move to that requester's OWN state next cycle.
  - Both valid: grant the requester that is not equal to `sel`, then set `sel` to the winner.
  - Both readies are 0 in IDLE.
- **OWNx**
  - reqx_ready = ~out_valid | out_ready. The other requester's ready is 0.
  - A transfer is reqx_valid & reqx_ready. On a transfer, load out_data and out_last from the requester and increment the beat counter.
- **Release:** a transfer with reqx_last = 1, or a transfer that brings the counter to MAX_BURST.
  - On release, go to IDLE next cycle and clear the counter.
  - A forced release does not alter out_last.
  - The requester may resume its burst after re-arbitration.
- **Output register**
  - Set out_valid on any transfer.
  - Clear out_valid when out_ready is high and no transfer occurs the same cycle.
  - A simultaneous drain and load keeps out_valid = 1 with the new data, which gives full throughput.
- The counter is 8 bits wide and never wraps, because release occurs at MAX_BURST.
- Valid deasserting mid-burst does not release the grant. The owner keeps the bus until its last beat or until MAX_BURST.

## Timing
- Reset values: state IDLE, sel = 1 (so requester 0 wins the first tie), counter 0, out_valid 0, out_data 0, out_last 0, busy 0, req0_ready 0, req1_ready 0.
- Readies and busy are combinational from state and the output register. All other outputs are registered.
- Arbitration latency is 1 cycle: a valid seen in IDLE at edge N gives ready at cycle N+1.
- Beat latency is 1 cycle: a beat accepted at edge N appears as out_valid/out_data after edge N.
- Each release costs one IDLE bubble cycle before the next grant, so there is no back-to-back handoff.
- Single-beat bursts therefore sustain at most 1 beat per 2 cycles.
- Asserting reset_n low mid-burst clears all state immediately. An in-flight out_valid beat is dropped, with no recovery.

## Configuration
- BUS_ARB_FIXED_PRIO_EN defined: on a tie in IDLE, requester 0 always wins, and `sel` no longer affects arbitration. `sel` still tracks the owner. MAX_BURST forced release still applies.
- Undefined (default): round-robin tie-break as described in Operation.

## Test plan
- **Reset priority:** both valid from reset, both single-beat with last=1, data 4'hA and 4'h5, out_ready=1 -> out_data 4'hA first, then 4'h5; sel goes 0 then 1.
- **Burst hold:** req0 sends a 3-beat burst 1,2,3 with req1 valid throughout -> out sequence 1,2,3, and req1_ready stays 0 until after the IDLE cycle following beat 3.
- **Forced release:** MAX_BURST=2, req0 streams 4 beats with last=0 and req1 valid -> req0 releases after 2 beats and req1 gets the next grant.
- **Backpressure:** out_ready=0 with one beat held -> owner ready=0 and out_data stable. Raise out_ready -> the next beat loads in the same cycle and out_valid stays 1.
- **Reset mid-burst:** assert reset_n low in OWN1 with out_valid=1 -> out_valid=0, busy=0, sel=1, both readies 0 immediately.
- **Fixed-priority build:** with BUS_ARB_FIXED_PRIO_EN defined, both requesters repeatedly valid with single-beat bursts -> requester 0 wins every arbitration.
